// File: rtl/alu_seq_if.sv
// alu_seq_if: command, external-ALU and result bus for alu_seq.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic [3:0] acc;
  logic [7:0] ops_done;
  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_y, alu_carry, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_zero, acc, ops_done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_y, alu_carry, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_zero, acc, ops_done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: accumulator sequencer around an external combinational ALU with
// valid/ready command and result handshakes.
module alu_seq #(
  parameter logic [2:0] LOAD_OP = 3'b111,
  parameter logic [2:0] CLR_OP  = 3'b110
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state_q;
  logic [2:0] op_q;
  logic [3:0] data_q;
  logic [3:0] acc_q;
  logic [3:0] res_data_q;
  logic       res_carry_q;
  logic       res_valid_q;
  logic       cmd_ready_q;
  logic [7:0] ops_done_q;
  logic [3:0] acc_d;
  logic       carry_d;
  // LOAD and CLR bypass the ALU and always report no carry
  always_comb begin
    acc_d   = op_q == LOAD_OP ? data_q : op_q == CLR_OP ? 4'd0 : bus.alu_y;
    carry_d = (op_q == LOAD_OP || op_q == CLR_OP) ? 1'b0 : bus.alu_carry;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      data_q      <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            data_q      <= bus.cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        EXEC: begin
          acc_q       <= acc_d;
          res_data_q  <= acc_d;
          res_carry_q <= carry_d;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            ops_done_q  <= ops_done_q == 8'hFF ? ops_done_q : ops_done_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = data_q;
  assign bus.alu_sel   = op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_data_q == 4'd0;
  assign bus.acc       = acc_q;
  assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq with a behavioural 4-bit ALU attached.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_ops = 0;
  alu_seq_if b ();
  alu_seq dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always_comb begin
    b.alu_y = 4'd0;
    b.alu_carry = 1'b0;
    case (b.alu_sel)
      3'b000: {b.alu_carry, b.alu_y} = {1'b0, b.alu_a} + {1'b0, b.alu_b};
      3'b001: {b.alu_carry, b.alu_y} = {1'b0, b.alu_a} - {1'b0, b.alu_b};
      3'b010: b.alu_y = b.alu_a & b.alu_b;
      3'b011: b.alu_y = b.alu_a | b.alu_b;
      3'b100: b.alu_y = b.alu_a ^ b.alu_b;
      default: ;
    endcase
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [3:0] d);
    int k = 0;
    while (!b.cmd_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", 8'(b.cmd_ready), 1);
    b.cmd_op = op;
    b.cmd_data = d;
    b.cmd_valid = 1'b1;
    @(posedge clk); #1;
    b.cmd_valid = 1'b0;
  endtask
  task automatic take();
    b.res_ready = 1'b1;
    @(posedge clk); #1;
    b.res_ready = 1'b0;
    exp_ops = exp_ops == 255 ? 255 : exp_ops + 1;
  endtask
  task automatic result(input string tag, input logic [3:0] d, input logic c, input logic z);
    chk({tag, "_valid"}, 8'(b.res_valid), 1);
    chk({tag, "_data"}, 8'(b.res_data), 8'(d));
    chk({tag, "_carry"}, 8'(b.res_carry), 8'(c));
    chk({tag, "_zero"}, 8'(b.res_zero), 8'(z));
    chk({tag, "_acc"}, 8'(b.acc), 8'(d));
  endtask
  initial begin
    b.cmd_valid = 1'b0;
    b.cmd_op = 3'd0;
    b.cmd_data = 4'd0;
    b.res_ready = 1'b0;
    #12;
    chk("rst_valid", 8'(b.res_valid), 0);
    chk("rst_acc", 8'(b.acc), 0);
    chk("rst_ops", b.ops_done, 0);
    chk("rst_data", 8'(b.res_data), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 8'(b.cmd_ready), 1);
    send(3'b111, 4'd5);
    chk("exec_ready", 8'(b.cmd_ready), 0);
    chk("exec_valid", 8'(b.res_valid), 0);
    @(posedge clk); #1;
    result("load5", 4'd5, 1'b0, 1'b0);
    take();
    chk("load5_done_valid", 8'(b.res_valid), 0);
    chk("load5_done_ready", 8'(b.cmd_ready), 1);
    chk("load5_ops", b.ops_done, 8'(exp_ops));
    send(3'b111, 4'd9); @(posedge clk); #1; take();
    send(3'b000, 4'd8);
    chk("add_alu_a", 8'(b.alu_a), 8'h9);
    chk("add_alu_b", 8'(b.alu_b), 8'h8);
    chk("add_alu_sel", 8'(b.alu_sel), 8'h0);
    @(posedge clk); #1;
    result("add", 4'd1, 1'b1, 1'b0);
    take();
    send(3'b111, 4'd3); @(posedge clk); #1; take();
    send(3'b001, 4'd5); @(posedge clk); #1;
    result("sub", 4'hE, 1'b1, 1'b0);
    take();
    send(3'b111, 4'hA); @(posedge clk); #1; take();
    send(3'b100, 4'hA); @(posedge clk); #1;
    result("xor", 4'h0, 1'b0, 1'b1);
    take();
    send(3'b101, 4'h3); @(posedge clk); #1;
    result("op101", 4'h0, 1'b0, 1'b1);
    take();
    send(3'b111, 4'hC); @(posedge clk); #1; take();
    send(3'b010, 4'hA); @(posedge clk); #1;
    result("and", 4'h8, 1'b0, 1'b0);
    take();
    send(3'b011, 4'h3); @(posedge clk); #1;
    result("or", 4'hB, 1'b0, 1'b0);
    take();
    send(3'b110, 4'h7); @(posedge clk); #1;
    result("clr", 4'h0, 1'b0, 1'b1);
    take();
    send(3'b111, 4'h6); @(posedge clk); #1;
    b.cmd_valid = 1'b1;
    b.cmd_op = 3'b000;
    b.cmd_data = 4'h1;
    for (int i = 0; i < 5; i++) begin
      result("hold", 4'h6, 1'b0, 1'b0);
      chk("hold_ready", 8'(b.cmd_ready), 0);
      chk("hold_ops", b.ops_done, 8'(exp_ops));
      @(posedge clk); #1;
    end
    b.cmd_valid = 1'b0;
    take();
    chk("hold_done_valid", 8'(b.res_valid), 0);
    chk("hold_done_ops", b.ops_done, 8'(exp_ops));
    chk("hold_ignored_acc", 8'(b.acc), 8'h6);
    send(3'b111, 4'h4);
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", 8'(b.acc), 0);
    chk("midrst_valid", 8'(b.res_valid), 0);
    chk("midrst_ops", b.ops_done, 0);
    chk("midrst_sel", 8'(b.alu_sel), 0);
    exp_ops = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 8'(b.cmd_ready), 1);
    chk("midrst_valid2", 8'(b.res_valid), 0);
    for (int i = 0; i < 255; i++) begin
      send(3'b000, 4'(i));
      @(posedge clk); #1;
      take();
    end
    chk("ops_255", b.ops_done, 8'd255);
    send(3'b000, 4'd1); @(posedge clk); #1; take();
    chk("ops_sat", b.ops_done, 8'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter LOAD_OP, default 3'b111, the command opcode that loads cmd_data into the accumulator and bypasses the ALU.
REQ-002 SHALL have parameter CLR_OP, default 3'b110, the command opcode that clears the accumulator and bypasses the ALU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, LOAD_OP, CLR_OP, other values ALU default.
REQ-008 SHALL have port cmd_data  input  4  B operand or load value.
REQ-009 SHALL have port alu_a  output  4  ALU A operand, equal to accumulator.
REQ-010 SHALL have port alu_b  output  4  ALU B operand, equal to latched cmd_data.
REQ-011 SHALL have port alu_sel  output  3  ALU select, equal to latched cmd_op.
REQ-012 SHALL have port alu_y  input  4  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-013 SHALL have port alu_carry  input  1  ALU carry/borrow.
REQ-014 SHALL have port res_valid  output  1  result available.
REQ-015 SHALL have port res_ready  input  1  consumer takes result.
REQ-016 SHALL have port res_data  output  4  result value.
REQ-017 SHALL have port res_carry  output  1  result carry/borrow.
REQ-018 SHALL have port res_zero  output  1  high when res_data == 0.
REQ-019 SHALL have port acc  output  4  current accumulator.
REQ-020 SHALL have port ops_done  output  8  count of completed result handshakes.

Function
REQ-021 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-022 SHALL drive cmd_ready high only in IDLE.
REQ-023 SHALL latch cmd_op and cmd_data and move to EXEC on the edge where cmd_valid and cmd_ready are both high.
REQ-024 SHALL, in EXEC, write res_data and acc with alu_y and res_carry with alu_carry, unmodified (sub carry = borrow, A<B).
REQ-025 SHALL, in EXEC for LOAD_OP, write acc and res_data with the latched data and clear res_carry.
REQ-026 SHALL, in EXEC for CLR_OP, write acc and res_data with 0 and clear res_carry.
REQ-027 SHALL move from EXEC to RESP unconditionally, giving res_valid high on the 2nd edge after acceptance.
REQ-028 SHALL hold res_valid high in RESP, with res_data, res_carry, res_zero and acc stable, until res_ready is high.
REQ-029 SHALL return to IDLE and increment ops_done on the edge where res_valid and res_ready are both high.
REQ-030 SHALL saturate ops_done at 255.
REQ-031 SHALL keep res_valid low outside RESP.
REQ-032 SHALL keep res_data and res_carry at their last values outside RESP.
REQ-033 SHALL ignore cmd_valid outside IDLE; minimum command period is 3 cycles.
REQ-034 SHALL drive alu_a, alu_b and alu_sel from registers only, never combinationally from cmd_*.

Reset
REQ-035 SHALL, while rst_n is low, force state IDLE and set acc, latched op/data, res_data, res_carry and ops_done to 0, and res_valid to 0, independent of clk.
REQ-036 SHALL abandon any in-flight command on reset, including mid-EXEC or mid-RESP.
REQ-037 SHALL assert cmd_ready from the first clk edge after rst_n rises.

Verification
REQ-038 Reset, then LOAD_OP with data 5 -> res_valid on 2nd edge; res_data=5, carry=0, zero=0, acc=5.
REQ-039 acc=9, ADD 8 -> res_data=1, res_carry=1; acc=1.
REQ-040 acc=3, SUB 5 -> res_data=4'hE, res_carry=1; acc=4'hE.
REQ-041 acc=4'hA, XOR 4'hA -> res_data=0, res_zero=1; op 3'b101 -> res_data=0, carry=0.
REQ-042 res_ready low for 5 cycles in RESP -> res_valid and outputs held, cmd_ready=0, ops_done unchanged; res_ready high -> IDLE, ops_done+1.
REQ-043 rst_n low during EXEC -> immediate IDLE, acc=0, res_valid=0, ops_done=0; 256 completions -> ops_done=255.
